// File: rtl/mem_access_ctrl.sv
// SRAM access sequencer for the MAR/MDR interface: IDLE -> SETUP -> ACCESS (WAIT_CYC) -> HOLD.
// Strobes are decoded from the state and latched op; read data is captured on the last ACCESS edge.
module mem_access_ctrl #(
  parameter int N        = 16,
  parameter int WAIT_CYC = 2
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         REQ,
  input  logic         WE,
  input  logic [N-1:0] ADDR,
  input  logic [N-1:0] WDATA,
  output logic [N-1:0] RDATA,
  output logic         DONE,
  output logic         BUSY,
  output logic [N-1:0] SRAM_ADDR,
  output logic [N-1:0] SRAM_DQ_OUT,
  output logic         SRAM_DQ_OE,
  input  logic [N-1:0] SRAM_DQ_IN,
  output logic         CE_N,
  output logic         OE_N,
  output logic         WE_N
);

  localparam int CW = $clog2(WAIT_CYC + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_HOLD
  } state_t;

  state_t         state_q, state_d;
  logic           op_q, op_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   rdata_q, rdata_d;
  logic [N-1:0]   addr_q, addr_d;
  logic [N-1:0]   dqout_q, dqout_d;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      op_q    <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
      addr_q  <= '0;
      dqout_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      dqout_q <= dqout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    addr_d  = addr_q;
    dqout_d = dqout_q;
    case (state_q)
      S_IDLE: begin
        if (REQ) begin
          addr_d  = ADDR;
          dqout_d = WDATA;
          op_d    = WE;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        cnt_d   = CNT_LOAD;
        state_d = S_ACCESS;
      end
      S_ACCESS: begin
        // The strobe has been low for WAIT_CYC cycles once the counter reaches zero.
        if (cnt_q == '0) begin
          if (!op_q) rdata_d = SRAM_DQ_IN;
          state_d = S_HOLD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_HOLD:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Write data stays driven through SETUP and HOLD so it brackets the WE_N pulse.
  assign CE_N        = (state_q == S_IDLE);
  assign OE_N        = !((state_q == S_ACCESS) && !op_q);
  assign WE_N        = !((state_q == S_ACCESS) && op_q);
  assign SRAM_DQ_OE  = (state_q != S_IDLE) && op_q;
  assign DONE        = (state_q == S_HOLD);
  assign BUSY        = (state_q != S_IDLE);
  assign RDATA       = rdata_q;
  assign SRAM_ADDR   = addr_q;
  assign SRAM_DQ_OUT = dqout_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: two instances (WAIT_CYC=2 and 1) share stimulus, each with an SRAM
// emulation and a phase-count reference model; directed scenarios then randomized traffic.
module tb_mem_access_ctrl;

  logic        Clk = 1'b0;
  logic        Reset, REQ, WE;
  logic [15:0] ADDR, WDATA;

  logic [15:0] rdata[2], saddr[2], sdq_out[2], dq_in[2];
  logic        done[2], busy[2], dq_oe[2], ce_n[2], oe_n[2], we_n[2];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 Clk = ~Clk;

  mem_access_ctrl #(.N(16), .WAIT_CYC(2)) u0 (
    .Clk(Clk), .Reset(Reset), .REQ(REQ), .WE(WE), .ADDR(ADDR), .WDATA(WDATA),
    .RDATA(rdata[0]), .DONE(done[0]), .BUSY(busy[0]), .SRAM_ADDR(saddr[0]),
    .SRAM_DQ_OUT(sdq_out[0]), .SRAM_DQ_OE(dq_oe[0]), .SRAM_DQ_IN(dq_in[0]),
    .CE_N(ce_n[0]), .OE_N(oe_n[0]), .WE_N(we_n[0]));

  mem_access_ctrl #(.N(16), .WAIT_CYC(1)) u1 (
    .Clk(Clk), .Reset(Reset), .REQ(REQ), .WE(WE), .ADDR(ADDR), .WDATA(WDATA),
    .RDATA(rdata[1]), .DONE(done[1]), .BUSY(busy[1]), .SRAM_ADDR(saddr[1]),
    .SRAM_DQ_OUT(sdq_out[1]), .SRAM_DQ_OE(dq_oe[1]), .SRAM_DQ_IN(dq_in[1]),
    .CE_N(ce_n[1]), .OE_N(oe_n[1]), .WE_N(we_n[1]));

  function automatic logic [15:0] dflt(input logic [15:0] a);
    return {a[7:0], ~a[7:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // SRAM emulation: written while CE_N and WE_N are low, read only while OE_N is low.
  logic [15:0] sram[2][256];
  bit          sram_v[2][256];

  always @(posedge Clk)
    for (int i = 0; i < 2; i++)
      if (!ce_n[i] && !we_n[i]) begin
        sram[i][saddr[i][7:0]]   <= sdq_out[i];
        sram_v[i][saddr[i][7:0]] <= 1'b1;
      end

  assign dq_in[0] = !oe_n[0] ? (sram_v[0][saddr[0][7:0]] ? sram[0][saddr[0][7:0]] : dflt(saddr[0])) : 16'h0BAD;
  assign dq_in[1] = !oe_n[1] ? (sram_v[1][saddr[1][7:0]] ? sram[1][saddr[1][7:0]] : dflt(saddr[1])) : 16'h0BAD;

  // Reference model: m_ph = cycles since acceptance (-1 idle); 0 setup, 1..W access, W+1 hold.
  int          m_ph[2] = '{-1, -1};
  bit          m_op[2];
  logic [15:0] m_addr[2], m_wd[2], m_rd[2];
  logic [15:0] rm[2][256];
  bit          rv[2][256];

  always @(posedge Clk) begin
    for (int i = 0; i < 2; i++) begin
      int w;
      w = (i == 0) ? 2 : 1;
      if (m_ph[i] >= 1 && m_ph[i] <= w && m_op[i]) begin
        rm[i][m_addr[i][7:0]] = m_wd[i];
        rv[i][m_addr[i][7:0]] = 1'b1;
      end
      if (Reset) begin
        m_ph[i] = -1; m_op[i] = 1'b0;
        m_addr[i] = '0; m_wd[i] = '0; m_rd[i] = '0;
      end else if (m_ph[i] < 0) begin
        if (REQ) begin
          m_addr[i] = ADDR; m_wd[i] = WDATA; m_op[i] = WE; m_ph[i] = 0;
        end
      end else if (m_ph[i] == w + 1) begin
        m_ph[i] = -1;
      end else begin
        if (m_ph[i] == w && !m_op[i])
          m_rd[i] = rv[i][m_addr[i][7:0]] ? rm[i][m_addr[i][7:0]] : dflt(m_addr[i]);
        m_ph[i]++;
      end
    end
  end

  always @(negedge Clk) begin
    for (int i = 0; i < 2; i++) begin
      int  w, ph;
      bit  acc, act;
      w   = (i == 0) ? 2 : 1;
      ph  = m_ph[i];
      act = (ph >= 0);
      acc = (ph >= 1) && (ph <= w);
      chk($sformatf("d%0d.BUSY", i),        {31'b0, busy[i]},  {31'b0, act});
      chk($sformatf("d%0d.DONE", i),        {31'b0, done[i]},  {31'b0, ph == w + 1});
      chk($sformatf("d%0d.CE_N", i),        {31'b0, ce_n[i]},  {31'b0, !act});
      chk($sformatf("d%0d.OE_N", i),        {31'b0, oe_n[i]},  {31'b0, !(acc && !m_op[i])});
      chk($sformatf("d%0d.WE_N", i),        {31'b0, we_n[i]},  {31'b0, !(acc && m_op[i])});
      chk($sformatf("d%0d.DQ_OE", i),       {31'b0, dq_oe[i]}, {31'b0, act && m_op[i]});
      chk($sformatf("d%0d.RDATA", i),       {16'b0, rdata[i]},   {16'b0, m_rd[i]});
      chk($sformatf("d%0d.SRAM_ADDR", i),   {16'b0, saddr[i]},   {16'b0, m_addr[i]});
      chk($sformatf("d%0d.SRAM_DQ_OUT", i), {16'b0, sdq_out[i]}, {16'b0, m_wd[i]});
      chk($sformatf("d%0d.inv_oe_vs_drive", i), {31'b0, dq_oe[i] & ~oe_n[i]}, 32'd0);
      chk($sformatf("d%0d.inv_we_on_read", i),  {31'b0, ~we_n[i] & ~m_op[i]}, 32'd0);
      chk($sformatf("d%0d.inv_oe_we", i),       {31'b0, ~oe_n[i] & ~we_n[i]}, 32'd0);
      chk($sformatf("d%0d.inv_ce", i),          {31'b0, (~oe_n[i] | ~we_n[i]) & ce_n[i]}, 32'd0);
    end
  end

  // Window observation: j counts negedges since the sample right after the accepting edge.
  int          o_busy[2], o_we[2], o_oe[2], o_dqoe[2], o_done[2], o_dj1[2], o_dj2[2];
  logic [15:0] o_rd_done[2];

  task automatic observe(input int n, input int pulse_j);
    for (int i = 0; i < 2; i++) begin
      o_busy[i] = 0; o_we[i] = 0; o_oe[i] = 0; o_dqoe[i] = 0; o_done[i] = 0;
      o_dj1[i] = -1; o_dj2[i] = -1; o_rd_done[i] = '0;
    end
    for (int j = 0; j < n; j++) begin
      if (pulse_j >= 0 && j == pulse_j) begin
        REQ = 1'b1; WE = 1'b0; ADDR = 16'h1234;
      end else if (pulse_j >= 0 && j == pulse_j + 1) begin
        REQ = 1'b0;
      end
      for (int i = 0; i < 2; i++) begin
        if (busy[i])  o_busy[i]++;
        if (!we_n[i]) o_we[i]++;
        if (!oe_n[i]) o_oe[i]++;
        if (dq_oe[i]) o_dqoe[i]++;
        if (done[i]) begin
          o_done[i]++;
          if (o_dj1[i] < 0) begin
            o_dj1[i] = j; o_rd_done[i] = rdata[i];
          end else if (o_dj2[i] < 0) begin
            o_dj2[i] = j;
          end
        end
      end
      @(negedge Clk);
    end
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((busy[0] || busy[1]) && k < 20) begin
      @(negedge Clk);
      k++;
    end
    chk("wait_idle_timeout", {31'b0, busy[0] | busy[1]}, 32'd0);
  endtask

  initial begin
    Reset = 1'b1; REQ = 1'b0; WE = 1'b0; ADDR = '0; WDATA = '0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_strobes", {29'b0, ce_n[i], oe_n[i], we_n[i]}, 32'h7);
      chk("rst_dq_oe",   {31'b0, dq_oe[i]}, 32'd0);
      chk("rst_rdata",   {16'b0, rdata[i]}, 32'h0000);
      chk("rst_busy",    {31'b0, busy[i]}, 32'd0);
      chk("rst_done",    {31'b0, done[i]}, 32'd0);
    end
    Reset = 1'b0;

    // Write BEEF to 3000; inputs are scrambled right after acceptance.
    REQ = 1'b1; WE = 1'b1; ADDR = 16'h3000; WDATA = 16'hBEEF;
    @(negedge Clk);
    REQ = 1'b0; WE = 1'b0; ADDR = 16'h5A5A; WDATA = 16'h0000;
    chk("wr_sram_addr", {16'b0, saddr[0]}, 32'h3000);
    chk("wr_dq_out",    {16'b0, sdq_out[0]}, 32'hBEEF);
    observe(8, -1);
    chk("wr_we_low_w2",  o_we[0], 2);
    chk("wr_we_low_w1",  o_we[1], 1);
    chk("wr_oe_low",     o_oe[0], 0);
    chk("wr_done_cnt",   o_done[0], 1);
    chk("wr_done_j_w2",  o_dj1[0], 3);
    chk("wr_done_j_w1",  o_dj1[1], 2);
    chk("wr_busy_len",   o_busy[0], 4);
    chk("wr_rdata_kept", {16'b0, rdata[0]}, 32'h0000);

    // Read 3000 back.
    REQ = 1'b1; WE = 1'b0; ADDR = 16'h3000;
    @(negedge Clk);
    REQ = 1'b0;
    observe(8, -1);
    chk("rd_oe_low_w2",   o_oe[0], 2);
    chk("rd_oe_low_w1",   o_oe[1], 1);
    chk("rd_dq_oe_never", o_dqoe[0], 0);
    chk("rd_rdata_done",  {16'b0, o_rd_done[0]}, 32'hBEEF);
    chk("rd_rdata_held",  {16'b0, rdata[0]}, 32'hBEEF);
    chk("rd_rdata_w1",    {16'b0, rdata[1]}, 32'hBEEF);

    // REQ pulse during ACCESS must be ignored.
    REQ = 1'b1; WE = 1'b0; ADDR = 16'h3000;
    @(negedge Clk);
    REQ = 1'b0;
    observe(8, 1);
    chk("ign_done_cnt_w2", o_done[0], 1);
    chk("ign_done_cnt_w1", o_done[1], 1);
    chk("ign_sram_addr",   {16'b0, saddr[0]}, 32'h3000);

    // Reset during the ACCESS of a write.
    REQ = 1'b1; WE = 1'b1; ADDR = 16'h0040; WDATA = 16'h5555;
    @(negedge Clk);
    REQ = 1'b0;
    @(negedge Clk);
    chk("abort_we_low_before", {31'b0, we_n[0]}, 32'd0);
    Reset = 1'b1;
    @(negedge Clk);
    chk("abort_busy",  {31'b0, busy[0]}, 32'd0);
    chk("abort_we_n",  {31'b0, we_n[0]}, 32'd1);
    chk("abort_dq_oe", {31'b0, dq_oe[0]}, 32'd0);
    chk("abort_rdata", {16'b0, rdata[0]}, 32'h0000);
    Reset = 1'b0;
    observe(6, -1);
    chk("abort_no_done_w2", o_done[0], 0);
    chk("abort_no_done_w1", o_done[1], 0);

    // Back-to-back with REQ held: read 0001, then write 0002.
    REQ = 1'b1; WE = 1'b0; ADDR = 16'h0001;
    @(negedge Clk);
    WE = 1'b1; ADDR = 16'h0002; WDATA = 16'h0002;
    observe(12, -1);
    REQ = 1'b0;
    chk("b2b_period_w2",  o_dj2[0] - o_dj1[0], 5);
    chk("b2b_period_w1",  o_dj2[1] - o_dj1[1], 4);
    chk("b2b_oe_low_w1",  o_oe[1], 1);
    chk("b2b_oe_low_w2",  o_oe[0], 2);
    chk("b2b_rdata_dflt", {16'b0, o_rd_done[0]}, 32'h01FE);
    wait_idle();

    // Randomized traffic with occasional resets.
    for (int k = 0; k < 400; k++) begin
      Reset = ($urandom_range(0, 63) == 0);
      REQ   = ($urandom_range(0, 1) == 1);
      WE    = ($urandom_range(0, 1) == 1);
      ADDR  = {8'($urandom), 4'h0, 4'($urandom)};
      WDATA = 16'($urandom);
      @(negedge Clk);
    end
    Reset = 1'b0; REQ = 1'b0;
    wait_idle();
    @(negedge Clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
